// File: rtl/peripheral_bus_master.sv
// Single-outstanding initiator that turns valid/ready requests into register
// strobes/read-back selection or synchronous-memory word accesses.
module peripheral_bus_master #(
  parameter int REGS   = 3,
  parameter int MEM_AW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [MEM_AW:0]      req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_error,
  output logic [REGS-1:0]      reg_write_en,
  output logic [31:0]          reg_data_in,
  input  logic [REGS*32-1:0]   reg_data_out,
  output logic                 mem_write_en,
  output logic [MEM_AW-1:0]    mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam logic [MEM_AW-1:0] REGS_W = MEM_AW'(REGS);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_write;
  logic                r_space;
  logic                r_error;
  logic [MEM_AW-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                w_accept;
  logic                w_req_error;
  logic [REGS-1:0]     w_reg_hit;
  logic [31:0]         w_reg_rdata;

  assign w_accept    = req_valid && req_ready;
  assign w_req_error = !req_addr[MEM_AW] && (req_addr[MEM_AW-1:0] >= REGS_W);

  generate
    for (genvar gi = 0; gi < REGS; gi++) begin : g_reg_hit
      assign w_reg_hit[gi] = (r_addr == MEM_AW'(gi));
    end
  endgenerate

  always_comb begin
    w_reg_rdata = '0;
    for (int i = 0; i < REGS; i++) begin
      if (w_reg_hit[i]) w_reg_rdata = reg_data_out[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE:    w_state_next = (r_space && !r_write) ? S_MEM_WAIT : S_RESP;
      S_MEM_WAIT: w_state_next = S_RESP;
      S_RESP:     if (resp_ready) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (r_state == S_IDLE) && !reset;
    resp_valid   = (r_state == S_RESP);
    reg_write_en = '0;
    mem_write_en = 1'b0;
    if (r_state == S_ISSUE && r_write) begin
      if (r_space)       mem_write_en = 1'b1;
      else if (!r_error) reg_write_en = w_reg_hit;
    end
  end

  // Request fields are latched at accept and held until the next accept so the
  // memory address/data stay stable through the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_space <= 1'b0;
      r_error <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_space <= req_addr[MEM_AW];
        r_addr  <= req_addr[MEM_AW-1:0];
        r_wdata <= req_wdata;
        r_error <= w_req_error;
        r_rdata <= '0;
      end
      if (r_state == S_ISSUE && !r_space && !r_write && !r_error) r_rdata <= w_reg_rdata;
      if (r_state == S_MEM_WAIT) r_rdata <= mem_data_out;
    end
  end

  assign resp_rdata  = (r_state == S_RESP) ? r_rdata : '0;
  assign resp_error  = (r_state == S_RESP) && r_error;
  assign reg_data_in = r_wdata;
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;

endmodule
